// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller and its
// response buffer.
package fetch_ctrl_pkg;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Byte address to instruction ROM word index (4 KiB window, wraps freely).
  function automatic logic [9:0] word_index(input logic [31:0] addr);
    return addr[11:2];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Decode-side handshake between the fetch controller (master) and decode (slave).
interface fetch_ctrl_if;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (output out_valid, output out_pc, output out_instr, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_instr, output out_ready);

endinterface

// File: rtl/fetch_ctrl_fifo.sv
// Two-entry response buffer between the ROM pipeline and decode; flush empties
// it in one edge and push/pop together at full occupancy is legal.
module fetch_fifo
  import fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_r [2];
  logic         rd_ptr_r;
  logic         wr_ptr_r;
  logic [1:0]   count_r;
  logic         do_push_s;
  logic         do_pop_s;

  // Qualify requests against current occupancy so the buffer cannot over/underflow.
  always_comb begin
    do_pop_s  = pop && (count_r != 2'd0);
    do_push_s = push && ((count_r != 2'd2) || do_pop_s);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) wr_ptr_r <= ~wr_ptr_r;
      if (do_pop_s)  rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks pc through a one-cycle-latency ROM and
// buffers responses for decode, with redirect flush and fetch_en throttling.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_en,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic [9:0]   rom_addr,
  input  logic [31:0]  rom_instr,
  fetch_ctrl_if.master out
);

  localparam logic [0:0] ST_IDLE = FETCH_IDLE;
  localparam logic [0:0] ST_RUN  = FETCH_RUN;

  logic [0:0]   state_r;
  logic [0:0]   next_state_s;
  logic [31:0]  pc_r;
  logic         inflight_r;
  logic [31:0]  inflight_pc_r;
  logic [1:0]   fifo_count_s;
  fetch_entry_t fifo_head_s;
  fetch_entry_t push_entry_s;
  logic         pop_s;
  logic         push_s;
  logic         issue_s;
  logic [2:0]   occupancy_s;

  // Issue only when the buffer can absorb this response plus the one in flight.
  always_comb begin
    pop_s        = out.out_ready && (fifo_count_s != 2'd0) && !redirect;
    occupancy_s  = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s      = (state_r == ST_RUN) && fetch_en && !redirect && (occupancy_s <= 3'd1);
    push_s       = inflight_r && !redirect;
    push_entry_s = '{pc: inflight_pc_r, instr: rom_instr};
  end

  // Run/idle follows fetch_en; redirect never changes state.
  always_comb begin
    case (state_r)
      ST_IDLE: next_state_s = fetch_en ? ST_RUN : ST_IDLE;
      ST_RUN:  next_state_s = fetch_en ? ST_RUN : ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Fetch pointer, FSM and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      if (redirect) begin
        pc_r       <= {redirect_pc[31:2], 2'b00};
        inflight_r <= 1'b0;
      end else if (issue_s) begin
        inflight_r    <= 1'b1;
        inflight_pc_r <= pc_r;
        pc_r          <= pc_r + 32'd4;
      end else begin
        inflight_r <= 1'b0;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .count      (fifo_count_s),
    .head       (fifo_head_s)
  );

  // Present the buffer head, or a bubble when nothing is held.
  always_comb begin
    if (fifo_count_s != 2'd0) begin
      out.out_valid = 1'b1;
      out.out_pc    = fifo_head_s.pc;
      out.out_instr = fifo_head_s.instr;
    end else begin
      out.out_valid = 1'b0;
      out.out_pc    = 32'h0000_0000;
      out.out_instr = NOP_INSTR;
    end
  end

  assign rom_addr = word_index(pc_r);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the reference model is the ideal delivered
// stream (consecutive pcs from the last restart point, instr = ROM word).
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [9:0]  rom_addr;
  logic [31:0] rom_instr;

  fetch_ctrl_if dec ();

  fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_addr    (rom_addr),
    .rom_instr   (rom_instr),
    .out         (dec)
  );

  always #5 clk = ~clk;

  // Instruction ROM: synchronous read, data one cycle after the address.
  logic [31:0] rom [1024];
  always @(posedge clk) rom_instr <= rom[rom_addr];

  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_delivered = 0;
  fetch_entry_t exp_q [$];
  logic [31:0]  exp_next_pc;
  logic [31:0]  first_words [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: exp_next_pc, instr: rom[exp_next_pc[11:2]]});
      exp_next_pc = exp_next_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] addr);
    exp_q.delete();
    exp_next_pc = {addr[31:2], 2'b00};
    refill();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    refill();
  endtask

  // Monitor: pops the expected stream on every accepted entry.
  logic         hold_q = 1'b0;
  logic [31:0]  hold_pc;
  logic [31:0]  hold_instr;
  fetch_entry_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_q) begin
          check1("stall_valid", dec.out_valid, 1'b1);
          check("stall_pc", dec.out_pc, hold_pc);
          check("stall_instr", dec.out_instr, hold_instr);
        end
        if (!dec.out_valid) begin
          check("idle_pc", dec.out_pc, 32'h0000_0000);
          check("idle_instr", dec.out_instr, NOP);
        end
        if (dec.out_valid && dec.out_ready && !redirect) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: got pc %h expected nothing", dec.out_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", dec.out_pc, e.pc);
            check("sb_instr", dec.out_instr, e.instr);
          end
          n_delivered++;
        end
        hold_q     = dec.out_valid && !dec.out_ready && !redirect;
        hold_pc    = dec.out_pc;
        hold_instr = dec.out_instr;
      end else begin
        hold_q = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    first_words[0] = 32'h001a8193;
    first_words[1] = 32'h00250213;
    first_words[2] = 32'h00330313;
    first_words[3] = 32'h00a183b3;
    first_words[4] = 32'h004a8433;
    for (int i = 0; i < 1024; i++) rom[i] = (i < 5) ? first_words[i] : $urandom;

    rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    dec.out_ready = 1'b1;
    restart(RESET_PC);
    repeat (3) cyc();
    @(negedge clk);
    check1("rst_valid", dec.out_valid, 1'b0);
    check("rst_pc", dec.out_pc, 32'h0);
    check("rst_instr", dec.out_instr, NOP);
    check("rst_rom_addr", {22'b0, rom_addr}, {22'b0, RESET_PC[11:2]});
    cyc(); rst_n = 1'b1;

    // Back-to-back stream from reset: valid two cycles after the first issue.
    cyc(); fetch_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      @(negedge clk);
      check1("start_valid", dec.out_valid, (k >= 3));
      if (k >= 3) begin
        check("start_pc", dec.out_pc, 32'(4 * (k - 3)));
        check("start_instr", dec.out_instr, first_words[k - 3]);
      end
    end

    // One-cycle reset mid-stream.
    cyc(); rst_n = 1'b0;
    @(negedge clk);
    check1("pre_rst_valid", dec.out_valid, 1'b1);
    cyc(); rst_n = 1'b1; restart(RESET_PC);
    @(negedge clk);
    check1("midrst_valid", dec.out_valid, 1'b0);
    check("midrst_instr", dec.out_instr, NOP);
    check("midrst_pc", dec.out_pc, 32'h0);
    check("midrst_rom_addr", {22'b0, rom_addr}, {22'b0, RESET_PC[11:2]});

    // Backpressure for 5 cycles while pc 8 is presented.
    for (int k = 1; k <= 12; k++) begin
      cyc();
      dec.out_ready = (k < 5) || (k >= 10);
      @(negedge clk);
      check1("bp_valid", dec.out_valid, (k >= 3));
      if (k >= 3 && k <= 4) check("bp_pc", dec.out_pc, 32'(4 * (k - 3)));
      if (k >= 5 && k <= 10) check("bp_hold_pc", dec.out_pc, 32'h8);
      if (k >= 6 && k <= 9) check("bp_no_issue", {22'b0, rom_addr}, 32'd4);
      if (k == 11) check("bp_pc12", dec.out_pc, 32'hC);
      if (k == 12) check("bp_pc16", dec.out_pc, 32'h10);
    end

    // Redirect mid-stream to 0x40.
    repeat (2) cyc();
    cyc(); redirect = 1'b1; redirect_pc = 32'h40; restart(32'h40);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    check1("redir_valid1", dec.out_valid, 1'b0);
    cyc(); @(negedge clk);
    check1("redir_valid2", dec.out_valid, 1'b0);
    cyc(); @(negedge clk);
    check1("redir_valid3", dec.out_valid, 1'b1);
    check("redir_pc", dec.out_pc, 32'h40);

    // Redirect with a full buffer to an unaligned address at the ROM top.
    cyc(); dec.out_ready = 1'b0;
    repeat (4) cyc();
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_0FFE; restart(32'h0000_0FFE);
    cyc(); redirect = 1'b0; dec.out_ready = 1'b1;
    @(negedge clk);
    check("wrap_addr_ffc", {22'b0, rom_addr}, 32'h3FF);
    cyc(); @(negedge clk);
    check("wrap_addr_1000", {22'b0, rom_addr}, 32'h0);
    cyc(); @(negedge clk);
    check("wrap_pc_ffc", dec.out_pc, 32'h0000_0FFC);
    cyc(); @(negedge clk);
    check("wrap_pc_1000", dec.out_pc, 32'h0000_1000);
    check("wrap_instr", dec.out_instr, first_words[0]);

    // fetch_en dropped right after a single issue.
    cyc(); fetch_en = 1'b0;
    repeat (6) cyc();
    cyc(); redirect = 1'b1; redirect_pc = 32'h200; restart(32'h200);
    cyc(); redirect = 1'b0;
    repeat (2) cyc();
    d0 = n_delivered;
    cyc(); fetch_en = 1'b1;
    cyc();
    cyc(); fetch_en = 1'b0;
    repeat (8) cyc();
    @(negedge clk);
    check("single_issue_count", 32'(n_delivered - d0), 32'd1);
    check("single_issue_addr", {22'b0, rom_addr}, 32'h81);

    // Randomised traffic.
    d0 = n_delivered;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      fetch_en      = ($urandom % 8) != 0;
      dec.out_ready = ($urandom % 4) != 0;
      rst_n         = 1'b1;
      redirect      = 1'b0;
      if ($urandom % 50 == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
        restart(redirect_pc);
      end
      if ($urandom % 400 == 0) begin
        rst_n = 1'b0;
        restart(RESET_PC);
      end
    end
    cyc(); rst_n = 1'b1; redirect = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    check1("random_progress", (n_delivered - d0) > 500, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
